uart_tx_fifo: RTL and testbench

Parametrised UART transmitter for the APB peripheral subsystem. It replaces the fixed 8N1 transmitter and its external baud-tick generator with an integrated baud divider, a transmit FIFO, and per-frame runtime configuration of parity and stop bits. The APB register slice drives the write port and config inputs. `Txd` goes to the pad.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Parity over the low nbits of data; odd mode inverts the XOR.
    function automatic logic parity_bit(input logic [8:0] data,
                                        input int unsigned nbits,
                                        input logic mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and an overflow strobe.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]    level_reg, level_next;
    logic             full_reg, empty_reg;
    logic             push_ok, pop_ok;

    // Acceptance is judged on registered flags, so a same-cycle pop never frees space.
    assign push_ok    = push && !full_reg;
    assign pop_ok     = pop && !empty_reg;
    assign ovf        = push && full_reg;
    assign level_next = level_reg + LW'(push_ok) - LW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            level_reg <= level_next;
            full_reg  <= (level_next == LW'(DEPTH));
            empty_reg <= (level_next == '0);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign level = level_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated baud divider, transmit FIFO and per-frame
// parity/stop configuration latched when each frame is popped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         wr_en,
    input  logic [DATA_BITS-1:0]         wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    input  logic                         tx_enable,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic                         parity_en,
    input  logic                         parity_odd,
    input  logic                         two_stop,
    output logic                         Txd,
    output logic                         busy,
    output logic                         TxD_done
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    tx_state_t            state_reg, state_next;
    logic [DIV_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [3:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_en_reg, par_en_next;
    logic                 par_bit_reg, par_bit_next;
    logic                 two_stop_reg, two_stop_next;
    logic                 overflow_reg;

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_empty, fifo_ovf;
    logic                 pop, load, tick, start_frame;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (full),
        .empty (fifo_empty),
        .level (level),
        .ovf   (fifo_ovf)
    );

    assign empty = fifo_empty;

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)        overflow_reg <= 1'b0;
        else if (fifo_ovf) overflow_reg <= 1'b1;
        else if (ovf_clr)  overflow_reg <= 1'b0;
    end
    assign overflow = overflow_reg;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            div_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            div_reg      <= div_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            two_stop_reg <= two_stop_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        div_next      = div_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        two_stop_next = two_stop_reg;
        load          = 1'b0;
        TxD_done      = 1'b0;
        Txd           = IDLE_LEVEL;
        busy          = (state_reg != IDLE);
        tick          = (baud_cnt_reg == div_reg);
        start_frame   = tx_enable && !fifo_empty;

        if (state_reg != IDLE)
            baud_cnt_next = tick ? '0 : baud_cnt_reg + DIV_W'(1);

        case (state_reg)
            IDLE: begin
                if (start_frame) load = 1'b1;
            end
            START: begin
                Txd = 1'b0;
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                Txd = shift_reg[0];
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next   = par_en_reg ? PARITY : STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                Txd = par_bit_reg;
                if (tick) begin
                    state_next   = STOP;
                    bit_idx_next = '0;
                end
            end
            STOP: begin
                Txd = IDLE_LEVEL;
                if (tick) begin
                    if (two_stop_reg && bit_idx_reg == 4'd0) begin
                        bit_idx_next = 4'd1;
                    end else begin
                        TxD_done   = 1'b1;
                        state_next = IDLE;
                        if (start_frame) load = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Frame configuration is captured together with the popped data.
        if (load) begin
            state_next    = START;
            baud_cnt_next = '0;
            bit_idx_next  = '0;
            shift_next    = fifo_head;
            div_next      = baud_div;
            par_en_next   = parity_en;
            par_bit_next  = parity_bit(9'(fifo_head), DATA_BITS, parity_odd);
            two_stop_next = two_stop;
        end
    end

    assign pop = load;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit instance plus a 7-bit instance.
module tb_uart_tx_fifo;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        wr_en, wr_en7;
    logic [7:0]  wr_data;
    logic [6:0]  wr_data7;
    logic        ovf_clr, tx_enable, parity_en, parity_odd, two_stop;
    logic [15:0] baud_div;

    logic        full, empty, overflow, Txd, busy, TxD_done;
    logic [3:0]  level;
    logic        full7, empty7, overflow7, txd7, busy7, done7;
    logic [3:0]  level7;

    int checks   = 0;
    int failures = 0;
    int gap;

    always #5 PCLK = ~PCLK;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .ovf_clr(ovf_clr), .tx_enable(tx_enable), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .Txd(Txd), .busy(busy), .TxD_done(TxD_done)
    );

    uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(8), .DIV_W(16)) dut7 (
        .PCLK(PCLK), .PRESET(PRESET), .wr_en(wr_en7), .wr_data(wr_data7),
        .full(full7), .empty(empty7), .level(level7), .overflow(overflow7),
        .ovf_clr(ovf_clr), .tx_enable(tx_enable), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .Txd(txd7), .busy(busy7), .TxD_done(done7)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_txd(input bit w);
        return w ? txd7 : Txd;
    endfunction

    function automatic logic cur_done(input bit w);
        return w ? done7 : TxD_done;
    endfunction

    function automatic logic cur_busy(input bit w);
        return w ? busy7 : busy;
    endfunction

    // Waits for the start bit, then compares every cycle of the frame.
    task automatic check_frame(input string tag, input bit w, input int nd,
                               input logic [8:0] data, input bit pen, input bit exp_par,
                               input bit tstop, input int div, input bit expect_idle,
                               output int wait_cycles);
        int n, len, bad, dones, done_at;
        wait_cycles = 0;
        while (cur_txd(w) !== 1'b0 && wait_cycles < 400) begin
            step();
            wait_cycles++;
        end
        chk({tag, "_start_seen"}, 32'(wait_cycles < 400), 1);
        n = 2 + nd + int'(pen) + int'(tstop);
        len = n * (div + 1);
        bad = 0; dones = 0; done_at = -1;
        for (int c = 0; c < len; c++) begin
            int b;
            logic e;
            b = c / (div + 1);
            if (b == 0)                 e = 1'b0;
            else if (b <= nd)           e = data[b-1];
            else if (pen && b == nd+1)  e = exp_par;
            else                        e = 1'b1;
            if (cur_txd(w) !== e) bad++;
            if (cur_done(w) === 1'b1) begin
                dones++;
                done_at = c;
            end
            step();
        end
        chk({tag, "_bit_errors"}, 32'(bad), 0);
        chk({tag, "_done_count"}, 32'(dones), 1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(len - 1));
        chk({tag, "_busy_after"}, 32'(cur_busy(w)), expect_idle ? 0 : 1);
        $display("frame %s data=%0h len=%0d done_at=%0d bad=%0d", tag, data, len, done_at, bad);
    endtask

    initial begin
        PRESET = 1'b1; wr_en = 0; wr_en7 = 0; wr_data = '0; wr_data7 = '0;
        ovf_clr = 0; tx_enable = 1; baud_div = 16'd3;
        parity_en = 0; parity_odd = 0; two_stop = 0;
        step(); step();
        PRESET = 1'b0;

        // Reset values
        chk("rst_txd", Txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", TxD_done, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        step();

        // 1: 8N1, baud_div=3, 0x0E, with write-to-start latency
        wr_en = 1; wr_data = 8'h0E;
        step();
        wr_en = 0;
        chk("t1_empty_after_write", empty, 0);
        chk("t1_level_after_write", level, 1);
        chk("t1_txd_still_idle", Txd, 1);
        step();
        chk("t1_txd_start", Txd, 0);
        chk("t1_busy", busy, 1);
        chk("t1_level_after_pop", level, 0);
        check_frame("t1_8n1", 0, 8, 9'h00E, 0, 0, 0, 3, 1, gap);
        $display("t1 done");

        // 2: parity even (bit 1), then odd with two stops (bit 0)
        baud_div = 16'd1; parity_en = 1; parity_odd = 0; two_stop = 0;
        wr_en = 1; wr_data = 8'h0E; step(); wr_en = 0;
        check_frame("t2_even", 0, 8, 9'h00E, 1, 1, 0, 1, 1, gap);
        parity_odd = 1; two_stop = 1;
        wr_en = 1; wr_data = 8'h0E; step(); wr_en = 0;
        check_frame("t2_odd_2stop", 0, 8, 9'h00E, 1, 0, 1, 1, 1, gap);

        // 3: back-to-back frames at baud_div=0
        baud_div = 16'd0; parity_en = 0; parity_odd = 0; two_stop = 0;
        wr_en = 1; wr_data = 8'h55; step();
        wr_data = 8'hAA; step(); wr_en = 0;
        check_frame("t3_first", 0, 8, 9'h055, 0, 0, 0, 0, 0, gap);
        check_frame("t3_second", 0, 8, 9'h0AA, 0, 0, 0, 0, 1, gap);
        chk("t3_no_gap", 32'(gap), 0);

        // 4: overflow with tx disabled, then drain in order
        tx_enable = 0;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1; wr_data = 8'(8'h10 + i); step();
        end
        wr_en = 0;
        chk("t4_level", level, 8);
        chk("t4_full", full, 1);
        chk("t4_overflow", overflow, 1);
        chk("t4_busy_disabled", busy, 0);
        wr_en = 1; wr_data = 8'h99; ovf_clr = 1; step();
        wr_en = 0;
        chk("t4_ovf_clr_collision", overflow, 1);
        chk("t4_level_unchanged", level, 8);
        step();
        ovf_clr = 0;
        chk("t4_overflow_cleared", overflow, 0);
        chk("t4_level_after_clr", level, 8);
        tx_enable = 1;
        for (int i = 0; i < 8; i++) begin
            check_frame($sformatf("t4_frame%0d", i), 0, 8, 9'(8'h10 + i), 0, 0, 0, 0, i == 7, gap);
        end
        chk("t4_empty_after_drain", empty, 1);
        repeat (12) step();
        chk("t4_no_ninth_frame", busy, 0);

        // 5: asynchronous reset during DATA
        baud_div = 16'd3;
        wr_en = 1; wr_data = 8'hA5; step();
        wr_data = 8'h3C; step(); wr_en = 0;
        repeat (8) step();
        chk("t5_busy_before", busy, 1);
        chk("t5_level_before", level, 1);
        PRESET = 1'b1;
        #1;
        chk("t5_txd_async", Txd, 1);
        chk("t5_busy_async", busy, 0);
        chk("t5_level_async", level, 0);
        chk("t5_empty_async", empty, 1);
        step();
        PRESET = 1'b0;
        begin
            int bad5;
            bad5 = 0;
            for (int i = 0; i < 20; i++) begin
                if (TxD_done !== 1'b0 || Txd !== 1'b1 || busy !== 1'b0) bad5++;
                step();
            end
            chk("t5_quiet_after_reset", 32'(bad5), 0);
        end

        // 6: 7-bit instance, 0x7F even parity
        baud_div = 16'd1; parity_en = 1; parity_odd = 0; two_stop = 0;
        wr_en7 = 1; wr_data7 = 7'h7F; step(); wr_en7 = 0;
        check_frame("t6_7bit", 1, 7, 9'h07F, 1, 1, 0, 1, 1, gap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
